tile_raster_engine: RTL



---
 rtl/tile_raster_engine.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/tile_raster_engine.sv
// Triangle rasterizer: screen-clamped bbox walk with add-only edge functions, one triangle in flight.
// Define RASTER_BACKFACE_CULL_EN to drop clockwise (negative-area) triangles instead of rasterising them.

module tile_raster_edge #(
  parameter int CW        = 17,
  parameter int FRAC_BITS = 8,
  parameter int EW        = 2*CW+2
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [1:0][CW-1:0] a_in,
  input  logic [1:0][CW-1:0] b_in,
  input  logic [CW-1:0]      px_in,
  input  logic [CW-1:0]      py_in,
  input  logic               neg_in,
  input  logic               mul_en_in,
  input  logic               init_en_in,
  input  logic               step_x_in,
  input  logic               step_row_in,
  output logic [EW-1:0]      e_out
);
  function automatic logic signed [EW-1:0] sub_ext(input logic [CW-1:0] p, input logic [CW-1:0] q);
    logic signed [CW:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, q});
    return {{(EW-CW-1){d[CW]}}, d};
  endfunction

  logic signed [EW-1:0] m0_q, m0_d, m1_q, m1_d, e_q, e_d, row_q, row_d, sx_q, sx_d, sy_q, sy_d;
  logic signed [EW-1:0] e_init, sx_init, sy_init;

  always_comb begin
    m0_d    = m0_q;
    m1_d    = m1_q;
    e_d     = e_q;
    row_d   = row_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    e_init  = m0_q - m1_q;
    sx_init = sub_ext(b_in[1], a_in[1]) <<< FRAC_BITS;
    sy_init = sub_ext(a_in[0], b_in[0]) <<< FRAC_BITS;  // -(bx-ax) scaled
    if (mul_en_in) begin
      m0_d = sub_ext(px_in, a_in[0]) * sub_ext(b_in[1], a_in[1]);
      m1_d = sub_ext(py_in, a_in[1]) * sub_ext(b_in[0], a_in[0]);
    end
    if (init_en_in) begin
      e_d   = neg_in ? -e_init  : e_init;
      row_d = e_d;
      sx_d  = neg_in ? -sx_init : sx_init;
      sy_d  = neg_in ? -sy_init : sy_init;
    end else if (step_row_in) begin
      row_d = row_q + sy_q;
      e_d   = row_d;
    end else if (step_x_in) begin
      e_d   = e_q + sx_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m0_q <= '0; m1_q <= '0; e_q <= '0; row_q <= '0; sx_q <= '0; sy_q <= '0;
    end else begin
      m0_q <= m0_d; m1_q <= m1_d; e_q <= e_d; row_q <= row_d; sx_q <= sx_d; sy_q <= sy_d;
    end
  end

  assign e_out = e_q;
endmodule

module tile_raster_engine #(
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int INT_BITS  = 9,
  parameter int FRAC_BITS = 8,
  parameter int ID_W      = 16,
  localparam int CW = INT_BITS + FRAC_BITS,
  localparam int EW = 2*CW + 2,
  localparam int XW = $clog2(SCREEN_W),
  localparam int YW = $clog2(SCREEN_H)
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [2:0][1:0][CW-1:0]    vertices_in,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [XW-1:0]              frag_x_out,
  output logic [YW-1:0]              frag_y_out,
  output logic [2:0][EW-1:0]         edges_out,
  output logic [EW-1:0]              area_out,
  output logic [ID_W-1:0]            triangle_id_out,
  output logic                       busy_out
);
  typedef enum logic [2:0] {IDLE, SETUP, INIT1, INIT2, SCAN} state_t;
  typedef struct packed {
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [2:0][EW-1:0] e;
  } frag_t;

  function automatic logic signed [EW-1:0] sub_ext(input logic [CW-1:0] p, input logic [CW-1:0] q);
    logic signed [CW:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, q});
    return {{(EW-CW-1){d[CW]}}, d};
  endfunction

  function automatic logic signed [EW-1:0] edge_fn(input logic [1:0][CW-1:0] a, input logic [1:0][CW-1:0] b,
                                                   input logic [1:0][CW-1:0] p);
    return sub_ext(p[0], a[0]) * sub_ext(b[1], a[1]) - sub_ext(p[1], a[1]) * sub_ext(b[0], a[0]);
  endfunction

  // Two-flop release synchroniser; assertion still propagates asynchronously.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_t                 state_q, state_d;
  logic [2:0][1:0][CW-1:0] vtx_q, vtx_d;
  logic [ID_W-1:0]        id_cnt_q, id_cnt_d, tri_id_q, tri_id_d;
  logic [XW-1:0]          xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d;
  logic [YW-1:0]          ymin_q, ymin_d, ymax_q, ymax_d, y_q, y_d;
  logic                   bubble_q, bubble_d, neg_q, neg_d, vld_q, vld_d;
  logic [EW-1:0]          area_q, area_d;
  frag_t                  frag_q, frag_d;

  logic [INT_BITS-1:0]    vx_min, vx_max, vy_min, vy_max;
  logic signed [EW-1:0]   area_raw;
  logic                   cull, out_free, sample, covered;
  logic                   mul_en, init_en, step_x, step_row;
  logic [CW-1:0]          px, py;
  logic [2:0][EW-1:0]     e_w;

`ifdef RASTER_BACKFACE_CULL_EN
  assign cull = area_raw[EW-1];
`else
  assign cull = 1'b0;
`endif

  always_comb begin
    vx_min = vtx_q[0][0][CW-1:FRAC_BITS];
    vx_max = vx_min;
    vy_min = vtx_q[0][1][CW-1:FRAC_BITS];
    vy_max = vy_min;
    for (int i = 1; i < 3; i++) begin
      if (vtx_q[i][0][CW-1:FRAC_BITS] < vx_min) vx_min = vtx_q[i][0][CW-1:FRAC_BITS];
      if (vtx_q[i][0][CW-1:FRAC_BITS] > vx_max) vx_max = vtx_q[i][0][CW-1:FRAC_BITS];
      if (vtx_q[i][1][CW-1:FRAC_BITS] < vy_min) vy_min = vtx_q[i][1][CW-1:FRAC_BITS];
      if (vtx_q[i][1][CW-1:FRAC_BITS] > vy_max) vy_max = vtx_q[i][1][CW-1:FRAC_BITS];
    end
  end

  assign area_raw = edge_fn(vtx_q[1], vtx_q[2], vtx_q[0]);
  assign px       = (CW'(xmin_q) << FRAC_BITS) | (CW'(1) << (FRAC_BITS-1));
  assign py       = (CW'(ymin_q) << FRAC_BITS) | (CW'(1) << (FRAC_BITS-1));
  assign covered  = ~e_w[0][EW-1] & ~e_w[1][EW-1] & ~e_w[2][EW-1];
  assign out_free = !vld_q || ready_in;

  always_comb begin
    state_d  = state_q;  vtx_d   = vtx_q;   id_cnt_d = id_cnt_q; tri_id_d = tri_id_q;
    xmin_d   = xmin_q;   xmax_d  = xmax_q;  ymin_d   = ymin_q;   ymax_d   = ymax_q;
    x_d      = x_q;      y_d     = y_q;     bubble_d = bubble_q; neg_d    = neg_q;
    area_d   = area_q;   vld_d   = vld_q;   frag_d   = frag_q;
    mul_en   = 1'b0;     init_en = 1'b0;    step_x   = 1'b0;     step_row = 1'b0;
    sample   = 1'b0;
    case (state_q)
      IDLE: if (valid_in && ready_out) begin
        vtx_d    = vertices_in;
        tri_id_d = id_cnt_q;
        id_cnt_d = id_cnt_q + ID_W'(1);
        state_d  = SETUP;
      end
      SETUP: begin
        neg_d   = area_raw[EW-1];
        area_d  = area_raw[EW-1] ? -area_raw : area_raw;
        xmin_d  = vx_min[XW-1:0];
        ymin_d  = vy_min[YW-1:0];
        xmax_d  = (vx_max > INT_BITS'(SCREEN_W-1)) ? XW'(SCREEN_W-1) : vx_max[XW-1:0];
        ymax_d  = (vy_max > INT_BITS'(SCREEN_H-1)) ? YW'(SCREEN_H-1) : vy_max[YW-1:0];
        // A min beyond the screen edge means the whole triangle lies off-screen.
        state_d = (area_raw == '0 || cull || vx_min > INT_BITS'(SCREEN_W-1) ||
                   vy_min > INT_BITS'(SCREEN_H-1)) ? IDLE : INIT1;
      end
      INIT1: begin
        mul_en   = 1'b1;
        x_d      = xmin_q;
        y_d      = ymin_q;
        bubble_d = 1'b0;
        state_d  = INIT2;
      end
      INIT2: begin
        init_en = 1'b1;
        state_d = SCAN;
      end
      SCAN: if (out_free) begin
        if (bubble_q) begin
          step_row = 1'b1;
          bubble_d = 1'b0;
          x_d      = xmin_q;
          y_d      = y_q + YW'(1);
        end else begin
          sample = 1'b1;
          if (x_q == xmax_q) begin
            if (y_q == ymax_q) state_d = IDLE;
            else               bubble_d = 1'b1;
          end else begin
            step_x = 1'b1;
            x_d    = x_q + XW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (out_free) begin
      vld_d = sample && covered;
      if (sample) begin
        frag_d.x = x_q;
        frag_d.y = y_q;
        frag_d.e = e_w;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; vtx_q <= '0;  id_cnt_q <= '0; tri_id_q <= '0;
      xmin_q  <= '0;   xmax_q <= '0; ymin_q   <= '0; ymax_q   <= '0;
      x_q     <= '0;   y_q    <= '0; bubble_q <= 1'b0; neg_q  <= 1'b0;
      area_q  <= '0;   vld_q  <= 1'b0; frag_q <= '0;
    end else begin
      state_q <= state_d; vtx_q <= vtx_d;   id_cnt_q <= id_cnt_d; tri_id_q <= tri_id_d;
      xmin_q  <= xmin_d;  xmax_q <= xmax_d; ymin_q   <= ymin_d;   ymax_q   <= ymax_d;
      x_q     <= x_d;     y_q    <= y_d;    bubble_q <= bubble_d; neg_q    <= neg_d;
      area_q  <= area_d;  vld_q  <= vld_d;  frag_q   <= frag_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_edge
    tile_raster_edge #(.CW(CW), .FRAC_BITS(FRAC_BITS), .EW(EW)) u_edge (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .a_in        (vtx_q[(i+1)%3]),
      .b_in        (vtx_q[(i+2)%3]),
      .px_in       (px),
      .py_in       (py),
      .neg_in      (neg_q),
      .mul_en_in   (mul_en),
      .init_en_in  (init_en),
      .step_x_in   (step_x),
      .step_row_in (step_row),
      .e_out       (e_w[i])
    );
  end

  assign ready_out       = (state_q == IDLE) && !vld_q && rst_n;
  assign valid_out       = vld_q;
  assign frag_x_out      = frag_q.x;
  assign frag_y_out      = frag_q.y;
  assign edges_out       = frag_q.e;
  assign area_out        = area_q;
  assign triangle_id_out = tri_id_q;
  assign busy_out        = (state_q != IDLE);
endmodule
